// File: rtl/lm75a_temp_fmt.sv
// LM75A temperature word -> sign + BCD digits via iterative double-dabble, plus OS-style alarm.
// Optional: define LM75A_FAULT_QUEUE_EN to require FAULT_Q consecutive qualifying conversions.
module lm75a_temp_fmt #(
    parameter logic signed [8:0] OS_TH   = 9'sd160,
    parameter logic signed [8:0] HYST_TH = 9'sd150
`ifdef LM75A_FAULT_QUEUE_EN
    ,
    parameter int unsigned       FAULT_Q = 4
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] temp_raw,
    input  logic        temp_valid,
    output logic        busy,
    output logic        out_valid,
    output logic        sign,
    output logic [3:0]  bcd_hund,
    output logic [3:0]  bcd_tens,
    output logic [3:0]  bcd_ones,
    output logic [3:0]  bcd_tenth,
    output logic        os_alarm
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [7:0]         int_q, int_d;
    logic [11:0]        bcd_q, bcd_d;
    logic [2:0]         frac_q, frac_d;
    logic               neg_q, neg_d;
    logic signed [8:0]  c_q, c_d;
    logic               pend_vld_q, pend_vld_d;
    logic [10:0]        pend_q, pend_d;
    logic               busy_q, busy_d;
    logic               out_valid_q, out_valid_d;
    logic               sign_q, sign_d;
    logic [3:0]         hund_q, hund_d, tens_q, tens_d, ones_q, ones_d, tenth_q, tenth_d;
    logic               alarm_q, alarm_d;
`ifdef LM75A_FAULT_QUEUE_EN
    logic [2:0]         fq_cnt_q, fq_cnt_d;
`endif

    logic [10:0] t, mag;
    logic [11:0] adj;
    logic        qual;
    logic        unused_bits;
    assign unused_bits = ^temp_raw[4:0];

    // Tenths truncated from eighths: frac * 1.25, rounded down.
    function automatic logic [3:0] frac_tenth(input logic [2:0] f);
        case (f)
            3'd0: frac_tenth = 4'd0;
            3'd1: frac_tenth = 4'd1;
            3'd2: frac_tenth = 4'd2;
            3'd3: frac_tenth = 4'd3;
            3'd4: frac_tenth = 4'd5;
            3'd5: frac_tenth = 4'd6;
            3'd6: frac_tenth = 4'd7;
            default: frac_tenth = 4'd8;
        endcase
    endfunction

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        int_d       = int_q;
        bcd_d       = bcd_q;
        frac_d      = frac_q;
        neg_d       = neg_q;
        c_d         = c_q;
        pend_vld_d  = pend_vld_q;
        pend_d      = pend_q;
        busy_d      = busy_q;
        out_valid_d = 1'b0;
        sign_d      = sign_q;
        hund_d      = hund_q;
        tens_d      = tens_q;
        ones_d      = ones_q;
        tenth_d     = tenth_q;
        alarm_d     = alarm_q;
`ifdef LM75A_FAULT_QUEUE_EN
        fq_cnt_d    = fq_cnt_q;
`endif
        t           = '0;
        mag         = '0;
        adj         = '0;
        qual        = 1'b0;

        case (state_q)
            IDLE: begin
                // A fresh strobe is newer than anything pending.
                if (temp_valid || pend_vld_q) begin
                    t          = temp_valid ? temp_raw[15:5] : pend_q;
                    mag        = t[10] ? (~t + 11'd1) : t;
                    neg_d      = t[10];
                    int_d      = mag[10:3];
                    frac_d     = mag[2:0];
                    c_d        = t[10:2];
                    bcd_d      = '0;
                    cnt_d      = 4'd8;
                    busy_d     = 1'b1;
                    pend_vld_d = 1'b0;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                for (int i = 0; i < 3; i++) begin
                    adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3
                                                               : bcd_q[4*i +: 4];
                end
                {bcd_d, int_d} = {adj[10:0], int_q, 1'b0};
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = DONE;
            end
            DONE: begin
                sign_d      = neg_q;
                hund_d      = bcd_q[11:8];
                tens_d      = bcd_q[7:4];
                ones_d      = bcd_q[3:0];
                tenth_d     = frac_tenth(frac_q);
                qual        = alarm_q ? (c_q < HYST_TH) : (c_q >= OS_TH);
`ifdef LM75A_FAULT_QUEUE_EN
                if (!qual) begin
                    fq_cnt_d = '0;
                end else if (32'(fq_cnt_q) + 32'd1 >= FAULT_Q) begin
                    fq_cnt_d = '0;
                    alarm_d  = ~alarm_q;
                end else begin
                    fq_cnt_d = fq_cnt_q + 3'd1;
                end
`else
                if (qual) alarm_d = ~alarm_q;
`endif
                out_valid_d = 1'b1;
                busy_d      = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (state_q != IDLE && temp_valid) begin
            pend_vld_d = 1'b1;
            pend_d     = temp_raw[15:5];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            int_q       <= '0;
            bcd_q       <= '0;
            frac_q      <= '0;
            neg_q       <= 1'b0;
            c_q         <= '0;
            pend_vld_q  <= 1'b0;
            pend_q      <= '0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            sign_q      <= 1'b0;
            hund_q      <= '0;
            tens_q      <= '0;
            ones_q      <= '0;
            tenth_q     <= '0;
            alarm_q     <= 1'b0;
`ifdef LM75A_FAULT_QUEUE_EN
            fq_cnt_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            int_q       <= int_d;
            bcd_q       <= bcd_d;
            frac_q      <= frac_d;
            neg_q       <= neg_d;
            c_q         <= c_d;
            pend_vld_q  <= pend_vld_d;
            pend_q      <= pend_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            sign_q      <= sign_d;
            hund_q      <= hund_d;
            tens_q      <= tens_d;
            ones_q      <= ones_d;
            tenth_q     <= tenth_d;
            alarm_q     <= alarm_d;
`ifdef LM75A_FAULT_QUEUE_EN
            fq_cnt_q    <= fq_cnt_d;
`endif
        end
    end

    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign sign      = sign_q;
    assign bcd_hund  = hund_q;
    assign bcd_tens  = tens_q;
    assign bcd_ones  = ones_q;
    assign bcd_tenth = tenth_q;
    assign os_alarm  = alarm_q;
endmodule

// File: tb/tb_lm75a_temp_fmt.sv
// Directed scoreboard bench for lm75a_temp_fmt: digits, latency, alarm hysteresis, pending, reset.
module tb_lm75a_temp_fmt;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] temp_raw = '0;
    logic        temp_valid = 1'b0;
    logic        busy, out_valid, sign, os_alarm;
    logic [3:0]  bcd_hund, bcd_tens, bcd_ones, bcd_tenth;

    lm75a_temp_fmt dut (
        .clk(clk), .reset(reset), .temp_raw(temp_raw), .temp_valid(temp_valid),
        .busy(busy), .out_valid(out_valid), .sign(sign), .bcd_hund(bcd_hund),
        .bcd_tens(bcd_tens), .bcd_ones(bcd_ones), .bcd_tenth(bcd_tenth), .os_alarm(os_alarm)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       sign;
        logic [3:0] hund, tens, ones, tenth;
        logic       alarm;
    } exp_t;

    exp_t sb[$];
    int   ov_cyc[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    logic m_alarm = 1'b0;
    int   m_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference model: integer arithmetic on the raw word.
    function automatic exp_t model(input logic [15:0] r);
        exp_t e;
        int t, c, mag, ip, fr;
        logic q;
        t   = int'($signed(r[15:5]));
        c   = int'($signed(r[15:7]));
        mag = (t < 0) ? -t : t;
        ip  = mag / 8;
        fr  = mag % 8;
        e.sign  = (t < 0);
        e.hund  = 4'(ip / 100);
        e.tens  = 4'((ip / 10) % 10);
        e.ones  = 4'(ip % 10);
        e.tenth = 4'((fr * 10) / 8);
        q = m_alarm ? (c < 150) : (c >= 160);
`ifdef LM75A_FAULT_QUEUE_EN
        if (!q) m_cnt = 0;
        else if (m_cnt + 1 >= 4) begin m_cnt = 0; m_alarm = ~m_alarm; end
        else m_cnt = m_cnt + 1;
`else
        if (q) m_alarm = ~m_alarm;
`endif
        e.alarm = m_alarm;
        return e;
    endfunction

    always @(negedge clk) begin
        if (out_valid) begin
            ov_cyc.push_back(cyc);
            check("unexpected_out_valid", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check("sign",  32'(sign),      32'(e.sign));
                check("hund",  32'(bcd_hund),  32'(e.hund));
                check("tens",  32'(bcd_tens),  32'(e.tens));
                check("ones",  32'(bcd_ones),  32'(e.ones));
                check("tenth", 32'(bcd_tenth), 32'(e.tenth));
                check("alarm", 32'(os_alarm),  32'(e.alarm));
            end
        end
    end

    task automatic send(input logic [15:0] r, input bit push);
        @(negedge clk);
        temp_raw = r;
        temp_valid = 1'b1;
        if (push) sb.push_back(model(r));
        @(negedge clk);
        temp_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || busy) && n < 60) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    task automatic check_zero(input string name);
        check(name, {24'd0, busy, out_valid, sign, os_alarm, 4'd0} | 32'(bcd_hund | bcd_tens | bcd_ones | bcd_tenth), 32'd0);
    endtask

    logic [15:0] tbl[$];

    initial begin
        int c0;
        #12;
        check_zero("reset_state");
        @(negedge clk);
        reset = 1'b1;

        // Latency and busy window
        send(16'h1900, 1);
        check("busy_e0", 32'(busy), 32'd1);
        check("ov_e0",   32'(out_valid), 32'd0);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check("busy_window", 32'(busy), 32'd1);
            check("ov_early",    32'(out_valid), 32'd0);
        end
        @(negedge clk);
        check("ov_e9",   32'(out_valid), 32'd1);
        check("busy_e9", 32'(busy), 32'd0);
        @(negedge clk);
        check("ov_single", 32'(out_valid), 32'd0);
        drain();

        // Digit patterns, then alarm hysteresis, then fault-queue style sequence
        tbl = '{16'hFF80, 16'hC900, 16'h7D00, 16'h1920, 16'h8000, 16'h7FF0,
                16'h4A80, 16'h5000, 16'h4B00, 16'h4A80,
                16'h5000, 16'h5000, 16'h5000, 16'h1900,
                16'h5000, 16'h5000, 16'h5000, 16'h5000};
        foreach (tbl[i]) begin
            send(tbl[i], 1);
            drain();
        end
        check("alarm_after_seq", 32'(os_alarm), 32'd1);

        // Back-to-back via pending: strobes at cycles 0, 3, 5
        ov_cyc.delete();
        @(negedge clk);
        temp_raw = 16'h1900; temp_valid = 1'b1; sb.push_back(model(16'h1900));
        @(negedge clk);
        c0 = cyc;
        temp_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        temp_raw = 16'h0000; temp_valid = 1'b1;
        @(negedge clk);
        temp_valid = 1'b0;
        @(negedge clk);
        temp_raw = 16'h7D00; temp_valid = 1'b1; sb.push_back(model(16'h7D00));
        @(negedge clk);
        temp_valid = 1'b0;
        repeat (16) @(negedge clk);
        drain();
        check("b2b_count", 32'(ov_cyc.size()), 32'd2);
        if (ov_cyc.size() == 2) begin
            check("b2b_first",  32'(ov_cyc[0] - c0), 32'd9);
            check("b2b_second", 32'(ov_cyc[1] - c0), 32'd19);
        end

        // Reset mid-conversion
        send(16'hC900, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check_zero("reset_mid");
        m_alarm = 1'b0;
        m_cnt = 0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (15) @(negedge clk);
        check_zero("post_reset_idle");
        send(16'hFF80, 1);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation timeout");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/lm75a_temp_fmt.md
# lm75a_temp_fmt

Downstream consumer of the LM75A I2C reader's 16-bit temperature word. Converts the raw two's-complement reading (11 significant bits, 0.125 °C/LSB) into sign plus BCD hundreds/tens/ones/tenths digits using an iterative double-dabble engine. Also drives an over-temperature alarm with hysteresis that mirrors the LM75A OS comparator. Its outputs feed the seven-segment display driver and system alarm logic.

## Interface
- OS_TH, 9'sd160, alarm set threshold, signed, 0.5 °C/LSB (80.0 °C)
- HYST_TH, 9'sd150, alarm clear threshold, signed, 0.5 °C/LSB (75.0 °C); must be ≤ OS_TH
- FAULT_Q, 4, consecutive qualifying conversions required to change the alarm (1..6); used only with LM75A_FAULT_QUEUE_EN
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- temp_raw  input  16  LM75A temperature register, [15:5] valid, [4:0] ignored
- temp_valid  input  1  single-cycle strobe: temp_raw holds a new reading
- busy  output  1  conversion in progress
- out_valid  output  1  single-cycle strobe: digit outputs and os_alarm updated
- sign  output  1  1 = negative
- bcd_hund, bcd_tens, bcd_ones, bcd_tenth  output  4 each  magnitude digits
- os_alarm  output  1  over-temperature flag

## Operation
- Reset (asynchronous, reset low): every output 0, FSM IDLE, pending flag and fault counter cleared.
- FSM states: IDLE → SHIFT → DONE → IDLE.
- IDLE: temp_valid high → capture t = temp_raw[15:5] (signed 11-bit) and c = temp_raw[15:7] (signed 9-bit); sign = t[10]; mag = |t|; int = mag[10:3]; frac = mag[2:0]; load shift counter = 8; busy = 1; go SHIFT.
- SHIFT: per cycle, add 3 to each BCD nibble ≥ 5, then shift int's MSB in. Counter decrements; at 0 go DONE.
- DONE: register digits; tenth digit is truncated from frac: 0,1,2,3,5,6,7,8 for frac 0..7. Update alarm; pulse out_valid; busy = 0; go IDLE.
- Alarm, single-shot mode: alarm 0 and c ≥ OS_TH → set; alarm 1 and c < HYST_TH → clear; otherwise hold.
- Outputs hold their values between out_valid strobes.
- temp_valid while busy: temp_raw is latched into a one-deep pending register, latest wins. On DONE→IDLE the pending word starts the next conversion with no idle cycle.
- temp_valid coinciding with the DONE cycle: treated as pending.
- Range handled: -128.0 .. +127.875 °C. int ≤ 128, so the hundreds digit is at most 1.
- Reset mid-conversion: abandon immediately; no out_valid is produced.

## Timing
- Latency: temp_valid sampled at edge E0 → out_valid high after edge E0+9, for exactly one cycle.
- busy is high from after E0 through the DONE cycle, then falls together with out_valid.
- Throughput: one conversion per 10 cycles when back-to-back via pending.
- os_alarm changes only on the out_valid edge.

## Configuration
- LM75A_FAULT_QUEUE_EN defined:
  - The alarm changes only after FAULT_Q consecutive conversions satisfy the set (or clear) condition.
  - A 3-bit counter tracks qualifying conversions and resets on any non-qualifying conversion and on alarm change.
- Undefined: single-shot mode. The counter logic and FAULT_Q are absent.

## Test plan
- temp_raw=16'h1900 strobed → out_valid 9 cycles later; sign=0, digits 0,2,5,0; busy high during the 9 intervening cycles.
- 16'hFF80 → sign=1, 0,0,0,5; 16'hC900 → sign=1, 0,5,5,0; 16'h7D00 → 1,2,5,0; 16'h1920 → 0,2,5,1.
- Alarm hysteresis, single-shot: 16'h4A80 → os_alarm=0; 16'h5000 → 1; 16'h4B00 → still 1; 16'h4A80 → 0.
- With LM75A_FAULT_QUEUE_EN and FAULT_Q=4: sequence of 16'h5000 ×3, 16'h1900, 16'h5000 ×4 → os_alarm rises only on the 8th out_valid.
- Back-to-back: strobes at cycles 0, 3, and 5 (16'h1900, 16'h0000, 16'h7D00) → two out_valids at cycles 9 and 19, showing 25.0 then 125.0.
- Drive reset low at cycle 4 of a conversion → all outputs 0 immediately; no out_valid follows; the next strobe after release converts normally.
